// File: rtl/alu_pipe.sv
// alu_pipe: single-stage ALU with valid/ready handshakes on input and output.
// Define ALU_PIPE_MUL_EN to add the multi-cycle shift-add multiplier on opcode 1100.
module alu_pipe #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       function_select,
  input  logic [SHW-1:0]   shift,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] F,
  output logic             zero,
  output logic             neg,
  output logic             carry,
  output logic             overflow
);

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_AND  = 4'b0001;
  localparam logic [3:0] OP_SUB  = 4'b0010;
  localparam logic [3:0] OP_SLTU = 4'b0011;
  localparam logic [3:0] OP_NOT  = 4'b0100;
  localparam logic [3:0] OP_OR   = 4'b0101;
  localparam logic [3:0] OP_XOR  = 4'b0110;
  localparam logic [3:0] OP_SLL  = 4'b0111;
  localparam logic [3:0] OP_SRL  = 4'b1000;
  localparam logic [3:0] OP_SRA  = 4'b1001;
  localparam logic [3:0] OP_ADC  = 4'b1010;
  localparam logic [3:0] OP_SLT  = 4'b1011;
  localparam logic [3:0] OP_MUL  = 4'b1100;

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] f_q;
  logic             zero_q, neg_q, carry_q, overflow_q, outValid_q, cin_q;

  logic [WIDTH-1:0] res_d;
  logic             carry_d, overflow_d, cinUpdate, isMul;
  logic             inFire, busy, cinIn;
  logic             mulDone, mulCarry;
  logic [WIDTH-1:0] mulF;
  logic [WIDTH:0]   addSum, subDiff, sllWide;

  assign in_ready  = !rst && !busy && (!outValid_q || out_ready);
  assign inFire    = in_valid && in_ready;
  assign out_valid = outValid_q;
  assign F         = f_q;
  assign zero      = zero_q;
  assign neg       = neg_q;
  assign carry     = carry_q;
  assign overflow  = overflow_q;

  // The extra top bit of each wide result is the carry/borrow/last-shifted-out bit.
  assign cinIn   = (function_select == OP_ADC) ? cin_q : 1'b0;
  assign addSum  = {1'b0, A} + {1'b0, B} + {{WIDTH{1'b0}}, cinIn};
  assign subDiff = {1'b0, A} - {1'b0, B};
  assign sllWide = {1'b0, A} << shift;

  always_comb begin
    res_d      = '0;
    carry_d    = 1'b0;
    overflow_d = 1'b0;
    cinUpdate  = 1'b0;
    isMul      = 1'b0;
    case (function_select)
      OP_ADD, OP_ADC: begin
        res_d      = addSum[WIDTH-1:0];
        carry_d    = addSum[WIDTH];
        overflow_d = (A[WIDTH-1] == B[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
        cinUpdate  = 1'b1;
      end
      OP_SUB: begin
        res_d      = subDiff[WIDTH-1:0];
        carry_d    = subDiff[WIDTH];
        overflow_d = (A[WIDTH-1] != B[WIDTH-1]) && (res_d[WIDTH-1] != A[WIDTH-1]);
        cinUpdate  = 1'b1;
      end
      OP_AND:  res_d = A & B;
      OP_OR:   res_d = A | B;
      OP_XOR:  res_d = A ^ B;
      OP_NOT:  res_d = ~A;
      OP_SLTU: res_d = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLL: begin
        res_d   = sllWide[WIDTH-1:0];
        carry_d = sllWide[WIDTH];
      end
      OP_SRL:  res_d = A >> shift;
      OP_SRA:  res_d = $unsigned($signed(A) >>> shift);
`ifdef ALU_PIPE_MUL_EN
      OP_MUL:  isMul = 1'b1;
`endif
      default: res_d = '0;
    endcase
  end

  // Result register: a new single-cycle result or a finished multiply wins over draining.
  always_ff @(posedge clk) begin
    if (rst) begin
      f_q        <= '0;
      zero_q     <= 1'b0;
      neg_q      <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      outValid_q <= 1'b0;
      cin_q      <= 1'b0;
    end else if (inFire && !isMul) begin
      f_q        <= res_d;
      zero_q     <= (res_d == '0);
      neg_q      <= res_d[WIDTH-1];
      carry_q    <= carry_d;
      overflow_q <= overflow_d;
      outValid_q <= 1'b1;
      if (cinUpdate) cin_q <= carry_d;
    end else if (mulDone) begin
      f_q        <= mulF;
      zero_q     <= (mulF == '0);
      neg_q      <= mulF[WIDTH-1];
      carry_q    <= mulCarry;
      overflow_q <= 1'b0;
      outValid_q <= 1'b1;
    end else if (outValid_q && out_ready) begin
      outValid_q <= 1'b0;
    end
  end

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic {IDLE, BUSY} mulState_e;

  mulState_e          state_q;
  logic               busy_q;
  logic [2*WIDTH-1:0] mcand_q, prod_q, prodNext;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;

  assign prodNext = prod_q + (mplier_q[0] ? mcand_q : '0);
  assign busy     = busy_q;
  assign mulDone  = (state_q == BUSY) && (count_q == CW'(WIDTH - 1));
  assign mulF     = prodNext[WIDTH-1:0];
  assign mulCarry = |prodNext[2*WIDTH-1:WIDTH];

  // One multiplier bit per cycle; the last step's sum is loaded straight into F.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      mcand_q  <= '0;
      prod_q   <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (inFire && isMul) begin
            state_q  <= BUSY;
            busy_q   <= 1'b1;
            mcand_q  <= {{WIDTH{1'b0}}, A};
            mplier_q <= B;
            prod_q   <= '0;
            count_q  <= '0;
          end
        end
        BUSY: begin
          prod_q   <= prodNext;
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
          count_q  <= count_q + CW'(1);
          if (mulDone) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end
`else
  assign busy     = 1'b0;
  assign mulDone  = 1'b0;
  assign mulF     = '0;
  assign mulCarry = 1'b0;
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: directed and randomized checks of alu_pipe (WIDTH=8) against a
// behavioural integer model; define ALU_PIPE_MUL_EN to also exercise the multiplier.
module tb_alu_pipe;

  typedef struct packed {
    logic [7:0] f;
    logic       z;
    logic       n;
    logic       c;
    logic       v;
  } res_t;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] function_select;
  logic [2:0] shift;
  logic [7:0] A;
  logic [7:0] B;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] F;
  logic       zero, neg, carry, overflow;

  int   nChecks = 0;
  int   nPass   = 0;
  logic expCin  = 1'b0;

  alu_pipe #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .function_select(function_select), .shift(shift),
    .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready),
    .F(F), .zero(zero), .neg(neg), .carry(carry), .overflow(overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model computed with plain integer arithmetic on the operand values.
  function automatic res_t model(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                                 input logic [2:0] sh, input logic cin);
    res_t r;
    int ai, bi, sa, sb, x;
    ai = int'(a);
    bi = int'(b);
    sa = (ai >= 128) ? ai - 256 : ai;
    sb = (bi >= 128) ? bi - 256 : bi;
    x  = 0;
    r  = '0;
    case (op)
      4'd0: begin x = ai + bi; r.c = (x > 255); r.v = (sa + sb > 127) || (sa + sb < -128); end
      4'd10: begin
        x = ai + bi + int'(cin); r.c = (x > 255);
        r.v = (sa + sb + int'(cin) > 127) || (sa + sb + int'(cin) < -128);
      end
      4'd2: begin x = ai - bi; r.c = (ai < bi); r.v = (sa - sb > 127) || (sa - sb < -128); end
      4'd1: x = ai & bi;
      4'd5: x = ai | bi;
      4'd6: x = ai ^ bi;
      4'd4: x = 255 - ai;
      4'd3: x = (ai < bi) ? 1 : 0;
      4'd11: x = (sa < sb) ? 1 : 0;
      4'd7: begin x = ai << sh; r.c = x[8]; end
      4'd8: x = ai >> sh;
      4'd9: x = sa >>> sh;
`ifdef ALU_PIPE_MUL_EN
      4'd12: begin x = ai * bi; r.c = (x > 255); end
`endif
      default: x = 0;
    endcase
    r.f = x[7:0];
    r.z = (r.f == 8'h00);
    r.n = r.f[7];
    return r;
  endfunction

  function automatic logic [3:0] rand_op();
    logic [3:0] op;
    op = 4'($urandom_range(0, 15));
`ifdef ALU_PIPE_MUL_EN
    if (op == 4'd12) op = 4'd13;
`endif
    return op;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [3:0] op, input logic [7:0] a,
                       input logic [7:0] b, input logic [2:0] sh);
    in_valid        = v;
    function_select = op;
    A               = a;
    B               = b;
    shift           = sh;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    tick();
    tick();
    nChecks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL reset_valid got=%b exp=0", out_valid);
    else nPass++;
    nChecks++;
    if ({F, zero, neg, carry, overflow} !== 12'h000)
      $display("[TB] FAIL reset_outs got=%h exp=000", {F, zero, neg, carry, overflow});
    else nPass++;
    nChecks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL reset_ready got=%b exp=0", in_ready);
    else nPass++;
    rst = 1'b0;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL post_reset_ready got=%b exp=1", in_ready);
    else nPass++;
  endtask

  task automatic test_add_overflow();
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 8'h7F, 8'h01, 3'd0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    nChecks++;
    if (out_valid !== 1'b1) $display("[TB] FAIL add_valid got=%b exp=1", out_valid);
    else nPass++;
    nChecks++;
    if ({F, zero, neg, carry, overflow} !== {8'h80, 4'b0101})
      $display("[TB] FAIL add_ovf got=%h exp=%h", {F, zero, neg, carry, overflow}, {8'h80, 4'b0101});
    else nPass++;
    tick();
  endtask

  task automatic test_adc_chain();
    out_ready = 1'b1;
    drive(1'b1, 4'd0, 8'hFF, 8'h01, 3'd0);
    tick();
    nChecks++;
    if ({out_valid, F, zero, neg, carry, overflow} !== {1'b1, 8'h00, 4'b1010})
      $display("[TB] FAIL chain_add got=%h exp=%h", {out_valid, F, zero, neg, carry, overflow},
               {1'b1, 8'h00, 4'b1010});
    else nPass++;
    drive(1'b1, 4'd10, 8'h00, 8'h00, 3'd0);
    tick();
    nChecks++;
    if ({out_valid, F, zero, neg, carry, overflow} !== {1'b1, 8'h01, 4'b0000})
      $display("[TB] FAIL chain_adc got=%h exp=%h", {out_valid, F, zero, neg, carry, overflow},
               {1'b1, 8'h01, 4'b0000});
    else nPass++;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    tick();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 4'd2, 8'h03, 8'h05, 3'd0);
    tick();
    drive(1'b1, 4'd0, 8'h01, 8'h01, 3'd0);
    for (int i = 0; i < 3; i++) begin
      nChecks++;
      if ({out_valid, F, zero, neg, carry, overflow} !== {1'b1, 8'hFE, 4'b0110})
        $display("[TB] FAIL bp_hold[%0d] got=%h exp=%h", i, {out_valid, F, zero, neg, carry, overflow},
                 {1'b1, 8'hFE, 4'b0110});
      else nPass++;
      nChecks++;
      if (in_ready !== 1'b0) $display("[TB] FAIL bp_ready[%0d] got=%b exp=0", i, in_ready);
      else nPass++;
      tick();
    end
    out_ready = 1'b1;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL bp_release got=%b exp=1", in_ready);
    else nPass++;
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    nChecks++;
    if ({out_valid, F} !== {1'b1, 8'h02})
      $display("[TB] FAIL bp_simul got=%h exp=%h", {out_valid, F}, {1'b1, 8'h02});
    else nPass++;
    tick();
    nChecks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL bp_drain got=%b exp=0", out_valid);
    else nPass++;
  endtask

  task automatic test_shifts();
    out_ready = 1'b1;
    drive(1'b1, 4'd9, 8'h90, 8'h00, 3'd3);
    tick();
    nChecks++;
    if ({out_valid, F, zero, neg, carry, overflow} !== {1'b1, 8'hF2, 4'b0100})
      $display("[TB] FAIL sra got=%h exp=%h", {out_valid, F, zero, neg, carry, overflow},
               {1'b1, 8'hF2, 4'b0100});
    else nPass++;
    drive(1'b1, 4'd7, 8'h81, 8'h00, 3'd1);
    tick();
    nChecks++;
    if ({out_valid, F, zero, neg, carry, overflow} !== {1'b1, 8'h02, 4'b0010})
      $display("[TB] FAIL sll got=%h exp=%h", {out_valid, F, zero, neg, carry, overflow},
               {1'b1, 8'h02, 4'b0010});
    else nPass++;
    drive(1'b1, 4'd15, 8'hA5, 8'h5A, 3'd2);
    tick();
    nChecks++;
    if ({out_valid, F, zero, neg, carry, overflow} !== {1'b1, 8'h00, 4'b1000})
      $display("[TB] FAIL illegal got=%h exp=%h", {out_valid, F, zero, neg, carry, overflow},
               {1'b1, 8'h00, 4'b1000});
    else nPass++;
    nChecks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL illegal_ready got=%b exp=1", in_ready);
    else nPass++;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    tick();
  endtask

  task automatic test_random();
    logic       expValid, v, ordy, expRdy;
    res_t       expRes;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [2:0] sh;
    rst = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    tick();
    rst      = 1'b0;
    expValid = 1'b0;
    expCin   = 1'b0;
    expRes   = '0;
    for (int i = 0; i < 300; i++) begin
      v    = ($urandom_range(0, 3) != 0);
      ordy = ($urandom_range(0, 2) != 0);
      op   = rand_op();
      a    = 8'($urandom);
      b    = 8'($urandom);
      sh   = 3'($urandom);
      out_ready = ordy;
      drive(v, op, a, b, sh);
      #1;
      expRdy = !expValid || ordy;
      nChecks++;
      if (in_ready !== expRdy) $display("[TB] FAIL rand_ready[%0d] got=%b exp=%b", i, in_ready, expRdy);
      else nPass++;
      if (v && expRdy) begin
        expRes   = model(op, a, b, sh, expCin);
        expValid = 1'b1;
        if (op == 4'd0 || op == 4'd2 || op == 4'd10) expCin = expRes.c;
      end else if (expValid && ordy) begin
        expValid = 1'b0;
      end
      tick();
      nChecks++;
      if (out_valid !== expValid) $display("[TB] FAIL rand_valid[%0d] got=%b exp=%b", i, out_valid, expValid);
      else nPass++;
      if (expValid) begin
        nChecks++;
        if ({F, zero, neg, carry, overflow} !== expRes)
          $display("[TB] FAIL rand_out[%0d] op=%h got=%h exp=%h", i, op, {F, zero, neg, carry, overflow}, expRes);
        else nPass++;
      end
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    out_ready = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    res_t       expRes;
    logic [3:0] op;
    logic [7:0] a, b;
    logic [2:0] sh;
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      op = (i % 2 == 1) ? 4'd10 : rand_op();
      a  = 8'($urandom);
      b  = 8'($urandom);
      sh = 3'($urandom);
      drive(1'b1, op, a, b, sh);
      #1;
      nChecks++;
      if (in_ready !== 1'b1) $display("[TB] FAIL b2b_ready[%0d] got=%b exp=1", i, in_ready);
      else nPass++;
      expRes = model(op, a, b, sh, expCin);
      if (op == 4'd0 || op == 4'd2 || op == 4'd10) expCin = expRes.c;
      tick();
      nChecks++;
      if ({out_valid, F, zero, neg, carry, overflow} !== {1'b1, expRes})
        $display("[TB] FAIL b2b_out[%0d] op=%h got=%h exp=%h", i, op,
                 {out_valid, F, zero, neg, carry, overflow}, {1'b1, expRes});
      else nPass++;
    end
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    tick();
  endtask

`ifdef ALU_PIPE_MUL_EN
  task automatic test_mul();
    res_t       expRes;
    logic [7:0] a, b;
    out_ready = 1'b1;
    drive(1'b1, 4'd12, 8'h10, 8'h20, 3'd0);
    #1;
    nChecks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL mul_accept got=%b exp=1", in_ready);
    else nPass++;
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 8; i++) begin
      nChecks++;
      if ({in_ready, out_valid} !== 2'b00)
        $display("[TB] FAIL mul_busy[%0d] got=%b exp=00", i, {in_ready, out_valid});
      else nPass++;
      tick();
    end
    nChecks++;
    if ({in_ready, out_valid, F, zero, neg, carry, overflow} !== {2'b11, 8'h00, 4'b1010})
      $display("[TB] FAIL mul_result got=%h exp=%h", {in_ready, out_valid, F, zero, neg, carry, overflow},
               {2'b11, 8'h00, 4'b1010});
    else nPass++;
    for (int k = 0; k < 3; k++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      expRes = model(4'd12, a, b, 3'd0, 1'b0);
      drive(1'b1, 4'd12, a, b, 3'd0);
      tick();
      drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
      repeat (8) tick();
      nChecks++;
      if ({out_valid, F, zero, neg, carry, overflow} !== {1'b1, expRes})
        $display("[TB] FAIL mul_rand[%0d] got=%h exp=%h", k, {out_valid, F, zero, neg, carry, overflow},
                 {1'b1, expRes});
      else nPass++;
    end
    drive(1'b1, 4'd12, 8'h10, 8'h20, 3'd0);
    tick();
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    repeat (3) tick();
    rst = 1'b1;
    #1;
    nChecks++;
    if (in_ready !== 1'b0) $display("[TB] FAIL abort_rst_ready got=%b exp=0", in_ready);
    else nPass++;
    tick();
    rst = 1'b0;
    #1;
    nChecks++;
    if (in_ready !== 1'b1) $display("[TB] FAIL abort_ready got=%b exp=1", in_ready);
    else nPass++;
    for (int i = 0; i < 12; i++) begin
      nChecks++;
      if (out_valid !== 1'b0) $display("[TB] FAIL abort_valid[%0d] got=%b exp=0", i, out_valid);
      else nPass++;
      tick();
    end
  endtask
`else
  task automatic test_mul();
    out_ready = 1'b1;
    drive(1'b1, 4'd12, 8'h10, 8'h20, 3'd0);
    tick();
    nChecks++;
    if ({in_ready, out_valid, F, zero, neg, carry, overflow} !== {2'b11, 8'h00, 4'b1000})
      $display("[TB] FAIL mul_illegal got=%h exp=%h", {in_ready, out_valid, F, zero, neg, carry, overflow},
               {2'b11, 8'h00, 4'b1000});
    else nPass++;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    tick();
    nChecks++;
    if (out_valid !== 1'b0) $display("[TB] FAIL mul_illegal_drain got=%b exp=0", out_valid);
    else nPass++;
  endtask
`endif

  initial begin
    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 4'd0, 8'h00, 8'h00, 3'd0);
    test_reset();
    test_add_overflow();
    test_adc_chain();
    test_backpressure();
    test_shifts();
    test_random();
    test_back_to_back();
    test_mul();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
